// File: rtl/npu_stream_pkg.sv
// Shared stream types for the NPU result path.
// State encoding and the round-robin pick helper.
package npu_stream_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Widest request vector rr_pick can search.
  localparam int RR_MAX = 64;

  // First set bit of valid[n-1:0], searching from
  // ptr upward and wrapping. Returns ptr if none set.
  function automatic int rr_pick(
    input logic [RR_MAX-1:0] valid,
    input int                ptr,
    input int                n
  );
    logic [RR_MAX-1:0] rot;
    int                idx;
    int                pick;
    logic              found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n && !found) begin
        idx = (ptr + k) % n;
        rot = valid >> idx;
        if (rot[0]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux.sv
// Flat-bus N:1 mux, N = 2^SEL_WIDTH.
// din_flat: lane i at [WIDTH*i +: WIDTH]; sel picks dout.
module mux #(
  parameter int WIDTH     = 16,
  parameter int SEL_WIDTH = 2
) (
  input  logic [WIDTH*(1<<SEL_WIDTH)-1:0] din_flat,
  input  logic [SEL_WIDTH-1:0]            sel,
  output logic [WIDTH-1:0]                dout
);

  localparam int N = 1 << SEL_WIDTH;

  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        dout = din_flat[WIDTH*i +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Packet-locked round-robin arbiter onto one registered stream.
// req_*: N requesters; out_*: one-deep output stage; busy: locked.
module mux_rr_arbiter
  import npu_stream_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int BEAT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [(1<<SEL_WIDTH)-1:0]       req_valid,
  input  logic [(1<<SEL_WIDTH)-1:0]       req_last,
  input  logic [WIDTH*(1<<SEL_WIDTH)-1:0] req_data_flat,
  output logic [(1<<SEL_WIDTH)-1:0]       req_ready,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_last,
  output logic [SEL_WIDTH-1:0]            out_src,
  output logic [BEAT_WIDTH-1:0]           out_beat,
  input  logic                            out_ready,
  output logic                            busy
);

  localparam int N = 1 << SEL_WIDTH;

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  grant_q, grant_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BEAT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [SEL_WIDTH-1:0]  out_src_q, out_src_d;
  logic [BEAT_WIDTH-1:0] out_beat_q, out_beat_d;

  logic [RR_MAX-1:0]     valid_ext;
  logic [SEL_WIDTH-1:0]  pick;
  logic [WIDTH-1:0]      sel_data;
  logic                  load;
  logic                  accept;

  mux #(
    .WIDTH     (WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_mux (
    .din_flat (req_data_flat),
    .sel      (grant_q),
    .dout     (sel_data)
  );

  always_comb begin
    valid_ext        = '0;
    valid_ext[N-1:0] = req_valid;
  end

  assign pick = SEL_WIDTH'(rr_pick(valid_ext, int'(rr_ptr_q), N));

  // Output slot is free, or being emptied this cycle.
  assign load = !out_valid_q || out_ready;

  always_comb begin
    req_ready = '0;
    if (state_q == ST_LOCKED) begin
      req_ready[grant_q] = load;
    end
  end

  assign accept = req_valid[grant_q] && req_ready[grant_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    out_beat_d  = out_beat_q;
    // Drain also happens in IDLE.
    if (out_valid_q && out_ready && !accept) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          out_last_d  = req_last[grant_q];
          out_src_d   = grant_q;
          out_beat_d  = beat_cnt_q;
          beat_cnt_d  = (&beat_cnt_q) ? beat_cnt_q
                                      : beat_cnt_q + 1'b1;
          if (req_last[grant_q]) begin
            rr_ptr_d   = grant_q + 1'b1;
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      out_beat_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      out_beat_q  <= out_beat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign out_beat  = out_beat_q;
  assign busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: scoreboarded output stream
// plus per-scenario cycle checks.
module tb_mux_rr_arbiter;

  localparam int W  = 16;
  localparam int SW = 2;
  localparam int N  = 4;
  localparam int BW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [W*N-1:0]  req_data_flat;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [SW-1:0]   out_src;
  logic [BW-1:0]   out_beat;
  logic            out_ready = 1'b1;
  logic            busy;

  logic            rv [N];
  logic            rl [N];
  logic [W-1:0]    rd [N];

  always #5 clk = ~clk;

  always_comb begin
    req_valid     = '0;
    req_last      = '0;
    req_data_flat = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = rv[i];
      req_last[i]            = rl[i];
      req_data_flat[W*i +: W] = rd[i];
    end
  end

  mux_rr_arbiter #(
    .WIDTH      (W),
    .SEL_WIDTH  (SW),
    .BEAT_WIDTH (BW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data_flat (req_data_flat),
    .req_ready     (req_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_src       (out_src),
    .out_beat      (out_beat),
    .out_ready     (out_ready),
    .busy          (busy)
  );

  typedef struct packed {
    logic [W-1:0]  d;
    logic          l;
    logic [SW-1:0] s;
    logic [BW-1:0] b;
  } beat_t;

  beat_t exp_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  // Scoreboard: every output transfer pops one expected beat.
  beat_t mon_got;
  beat_t mon_exp;
  beat_t hold_v;
  bit    hold_q = 1'b0;

  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      mon_got = {out_data, out_last, out_src, out_beat};
      if (hold_q) begin
        tests_run++;
        if (mon_got !== hold_v) begin
          tests_failed++;
          $display("FAIL out_stable got %h required %h",
                   mon_got, hold_v);
        end
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_beat got %h required none",
                   mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            tests_failed++;
            $display("FAIL out_beat got d=%h l=%b s=%0d b=%0d required d=%h l=%b s=%0d b=%0d",
                     mon_got.d, mon_got.l, mon_got.s, mon_got.b,
                     mon_exp.d, mon_exp.l, mon_exp.s, mon_exp.b);
          end
        end
      end
      hold_q = out_valid && !out_ready;
      hold_v = mon_got;
    end else begin
      hold_q = 1'b0;
    end
  end

  // Upstream protocol: no drop/change while valid && !ready.
  logic [N-1:0] ph = '0;
  logic [W-1:0] pdat [N];

  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      ph = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ph[i]) begin
          assert (req_valid[i] &&
                  req_data_flat[W*i +: W] == pdat[i])
          else $error("protocol: req %0d dropped or changed", i);
        end
        ph[i]   = req_valid[i] && !req_ready[i];
        pdat[i] = req_data_flat[W*i +: W];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [W-1:0] d, input logic l,
                      input int s, input int b);
    beat_t x;
    x.d = d;
    x.l = l;
    x.s = SW'(s);
    x.b = (b > 3) ? BW'(3) : BW'(b);
    exp_q.push_back(x);
  endtask

  task automatic send_pkt(input int r, input int n,
                          input logic [W-1:0] d0,
                          input logic [W-1:0] step,
                          input int gap_after,
                          input int gap_len);
    int cnt;
    bit acc;
    @(negedge clk);
    for (int b = 0; b < n; b++) begin
      if (b == gap_after + 1 && gap_len > 0) begin
        rv[r] = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      rv[r] = 1'b1;
      rd[r] = d0 + step * W'(b);
      rl[r] = (b == n - 1);
      cnt = 0;
      acc = 1'b0;
      while (!acc && cnt < 200) begin
        #4;
        acc = req_ready[r];
        @(negedge clk);
        cnt++;
      end
      if (!acc) begin
        tests_run++;
        tests_failed++;
        $display("FAIL send_timeout req=%0d beat=%0d got no ready required ready",
                 r, b);
      end
    end
    rv[r] = 1'b0;
    rl[r] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0;
      rl[i] = 1'b0;
      rd[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain_check(input string name);
    repeat (6) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_leftover got %0d beats required 0",
               name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_out_valid got %b required 0", out_valid);
    end
    tests_run++;
    if (out_data !== '0) begin
      tests_failed++;
      $display("FAIL rst_out_data got %h required 0", out_data);
    end
    tests_run++;
    if ({out_last, out_src, out_beat} !== '0) begin
      tests_failed++;
      $display("FAIL rst_out_meta got %b%b%b required 0",
               out_last, out_src, out_beat);
    end
    tests_run++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      tests_failed++;
      $display("FAIL rst_busy_ready got %b/%b required 0/0",
               busy, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    tests_run++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      tests_failed++;
      $display("FAIL idle_no_req got %b/%b required 0/0",
               busy, req_ready);
    end
  endtask

  task automatic test_single_packet();
    logic [6:1] e_ov;
    logic [6:1] e_busy;
    logic [6:1] e_last;
    do_reset();
    e_ov   = 6'b001110;
    e_busy = 6'b000111;
    e_last = 6'b001000;
    push(16'h0011, 1'b0, 0, 0);
    push(16'h0022, 1'b0, 0, 1);
    push(16'h0033, 1'b1, 0, 2);
    fork
      send_pkt(0, 3, 16'h0011, 16'h0011, -1, 0);
      begin
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
          @(negedge clk);
          #4;
          tests_run++;
          if ({out_valid, busy, out_valid && out_last} !==
              {e_ov[k], e_busy[k], e_last[k]}) begin
            tests_failed++;
            $display("FAIL single_cycle%0d got v/b/l=%b%b%b required %b%b%b",
                     k, out_valid, busy, out_valid && out_last,
                     e_ov[k], e_busy[k], e_last[k]);
          end
        end
      end
    join
    drain_check("single");
  endtask

  task automatic test_round_robin();
    logic e_ov;
    do_reset();
    for (int i = 0; i < 4; i++) push(16'hA000 + W'(i), 1'b1, i, 0);
    push(16'hA000, 1'b1, 0, 0);
    fork
      begin
        send_pkt(0, 1, 16'hA000, 16'h0, -1, 0);
        send_pkt(0, 1, 16'hA000, 16'h0, -1, 0);
      end
      send_pkt(1, 1, 16'hA001, 16'h0, -1, 0);
      send_pkt(2, 1, 16'hA002, 16'h0, -1, 0);
      send_pkt(3, 1, 16'hA003, 16'h0, -1, 0);
      begin
        @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
          @(negedge clk);
          #4;
          e_ov = (k % 2 == 0) && (k <= 10);
          tests_run++;
          if (out_valid !== e_ov) begin
            tests_failed++;
            $display("FAIL rr_bubble_cycle%0d got %b required %b",
                     k, out_valid, e_ov);
          end
        end
      end
    join
    drain_check("rr");
  endtask

  task automatic test_lock_hold();
    do_reset();
    push(16'h1100, 1'b0, 1, 0);
    push(16'h1101, 1'b0, 1, 1);
    push(16'h1102, 1'b1, 1, 2);
    push(16'h2200, 1'b1, 2, 0);
    fork
      send_pkt(1, 3, 16'h1100, 16'h1, 0, 3);
      send_pkt(2, 1, 16'h2200, 16'h0, -1, 0);
      begin
        @(negedge clk);
        for (int k = 1; k <= 7; k++) begin
          @(negedge clk);
          #4;
          tests_run++;
          if ({busy, req_ready[2]} !== {k < 7, 1'b0}) begin
            tests_failed++;
            $display("FAIL lock_cycle%0d got busy/rdy2=%b%b required %b0",
                     k, busy, req_ready[2], k < 7);
          end
        end
        @(negedge clk);
        #4;
        tests_run++;
        if (req_ready !== 4'b0100) begin
          tests_failed++;
          $display("FAIL lock_regrant got %b required 0100",
                   req_ready);
        end
      end
    join
    drain_check("lock");
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int b = 0; b < 4; b++) push(16'h3300 + W'(b), b == 3, 3, b);
    fork
      send_pkt(3, 4, 16'h3300, 16'h1, -1, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
          #4;
          tests_run++;
          if ({out_valid, out_data, req_ready} !==
              {1'b1, 16'h3300, 4'b0000}) begin
            tests_failed++;
            $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b required v=1 d=3300 rdy=0000",
                     j, out_valid, out_data, req_ready);
          end
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain_check("bp");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int b = 0; b < 6; b++) push(16'h5500 + W'(b), b == 5, 2, b);
    send_pkt(2, 6, 16'h5500, 16'h1, -1, 0);
    drain_check("sat");
  endtask

  task automatic test_async_reset();
    do_reset();
    push(16'h7000, 1'b1, 0, 0);
    send_pkt(0, 1, 16'h7000, 16'h0, -1, 0);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    rv[1] = 1'b1;
    rd[1] = 16'h7100;
    rl[1] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    tests_run++;
    if ({out_valid, busy, out_src} !== {1'b1, 1'b1, 2'd1}) begin
      tests_failed++;
      $display("FAIL ar_pre got v/b/src=%b%b%0d required 111",
               out_valid, busy, out_src);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_data, out_last, out_src, out_beat,
         busy, req_ready} !== '0) begin
      tests_failed++;
      $display("FAIL ar_clear got v=%b d=%h l=%b s=%0d b=%0d busy=%b rdy=%b required all 0",
               out_valid, out_data, out_last, out_src, out_beat,
               busy, req_ready);
    end
    rv[1] = 1'b0;
    rl[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    push(16'h7200, 1'b1, 0, 0);
    push(16'h7101, 1'b1, 1, 0);
    fork
      send_pkt(0, 1, 16'h7200, 16'h0, -1, 0);
      send_pkt(1, 1, 16'h7101, 16'h0, -1, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        #4;
        tests_run++;
        if (req_ready !== 4'b0001) begin
          tests_failed++;
          $display("FAIL ar_restart got %b required 0001",
                   req_ready);
        end
      end
    join
    drain_check("ar");
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0;
      rl[i] = 1'b0;
      rd[i] = '0;
    end
    test_reset();
    test_single_packet();
    test_round_robin();
    test_lock_hold();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule
